// File: rtl/posit_defines.sv
// Shared constants and types for the posit exact-dot-product accumulator.
// Default geometry is NBITS=32 / ES=2; the derivation helpers let other sizes reuse the same formulas.
package posit_defines;

  localparam int DEF_NBITS = 32;
  localparam int DEF_ES    = 2;
  localparam int DEF_CBITS = 8;

  function automatic int calc_maxs(input int nbits, input int es);
    return (1 << es) * (nbits - 2);
  endfunction

  function automatic int calc_fbits(input int nbits, input int es);
    return nbits - 3 - es;
  endfunction

  function automatic int calc_mbits(input int nbits, input int es);
    return 2 * (calc_fbits(nbits, es) + 1);
  endfunction

  function automatic int calc_sw(input int nbits, input int es);
    return $clog2(2 * calc_maxs(nbits, es) + 1) + 1;
  endfunction

  function automatic int calc_qbits(input int nbits, input int es, input int cbits);
    return 4 * calc_maxs(nbits, es) + calc_mbits(nbits, es) + cbits;
  endfunction

  // Posit saturation: results never leave the representable scale range.
  function automatic int clamp_scale(input int s, input int lim);
    if (s > lim) return lim;
    if (s < -lim) return -lim;
    return s;
  endfunction

  localparam int MAXS          = calc_maxs(DEF_NBITS, DEF_ES);
  localparam int FBITS         = calc_fbits(DEF_NBITS, DEF_ES);
  localparam int MBITS         = calc_mbits(DEF_NBITS, DEF_ES);
  localparam int SW            = calc_sw(DEF_NBITS, DEF_ES);
  localparam int QBITS         = calc_qbits(DEF_NBITS, DEF_ES, DEF_CBITS);
  localparam int DEF_OUT_FBITS = FBITS;

  typedef struct packed {
    logic                     sgn;
    logic [SW-1:0]            scale;
    logic [DEF_OUT_FBITS-1:0] fraction;
    logic                     inf;
    logic                     zero;
  } value_quire_out;

  typedef enum logic [2:0] {
    ST_ACC,
    ST_ABS,
    ST_NORM,
    ST_ROUND,
    ST_OUT
  } acc_state_e;

endpackage

// File: rtl/posit_quire_align.sv
// Places one unpacked product into quire position (fraction << (scale + bias)) and applies its sign
// in two's complement so the quire only ever needs an adder.
module posit_quire_align
  import posit_defines::*;
#(
  parameter int SC_W = 9,
  parameter int M_W  = 56,
  parameter int Q_W  = 544,
  parameter int BIAS = 240
) (
  input  logic                   sgn,
  input  logic signed [SC_W-1:0] scale,
  input  logic [M_W-1:0]         frac,
  output logic [Q_W-1:0]         term
);

  localparam int SHW = $clog2(Q_W);

  logic [SC_W:0]    shift_s;
  logic [SHW-1:0]   shamt;
  logic [Q_W-1:0]   mag;

  always_comb begin
    shift_s = {scale[SC_W-1], scale} + (SC_W+1)'(BIAS);
    // A scale below the bias cannot come from a legal product; pin it to the bottom of the quire.
    shamt   = shift_s[SC_W] ? '0 : SHW'(shift_s[SC_W-1:0]);
    mag     = Q_W'(frac) << shamt;
    term    = sgn ? (~mag + Q_W'(1)) : mag;
  end

endmodule

// File: rtl/posit_dot_accum.sv
// Exact quire accumulator: sums unpacked posit products, then normalises to one unpacked result.
// Define POSIT_DOT_ACCUM_RNE_EN to round the output fraction to nearest-even (adds a ROUND state).
module posit_dot_accum
  import posit_defines::*;
#(
  parameter int NBITS     = DEF_NBITS,
  parameter int ES        = DEF_ES,
  parameter int CBITS     = DEF_CBITS,
  parameter int OUT_FBITS = NBITS - 3 - ES,
  parameter int CHUNK     = 16,
  localparam int MAX_SC   = calc_maxs(NBITS, ES),
  localparam int M_W      = calc_mbits(NBITS, ES),
  localparam int SC_W     = calc_sw(NBITS, ES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_last,
  input  logic                   in_sgn,
  input  logic signed [SC_W-1:0] in_scale,
  input  logic [M_W-1:0]         in_frac,
  input  logic                   in_inf,
  input  logic                   in_zero,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_sgn,
  output logic signed [SC_W-1:0] out_scale,
  output logic [OUT_FBITS-1:0]   out_frac,
  output logic                   out_inf,
  output logic                   out_zero
);

  localparam int Q_W = calc_qbits(NBITS, ES, CBITS);
  localparam int SHW = $clog2(Q_W + 1);
  localparam int PT  = 2 * MAX_SC + M_W - 2;  // quire bit holding weight 2^0

  acc_state_e                state_q, state_d;
  logic [Q_W-1:0]            quire_q, quire_d;
  logic                      nar_q, nar_d;
  logic                      sgn_q, sgn_d;
  logic [SHW-1:0]            sh_q, sh_d;
  logic                      out_sgn_q, out_sgn_d;
  logic signed [SC_W-1:0]    out_scale_q, out_scale_d;
  logic [OUT_FBITS-1:0]      out_frac_q, out_frac_d;
  logic                      out_inf_q, out_inf_d;
  logic                      out_zero_q, out_zero_d;

  logic [Q_W-1:0]            term;
  int                        scale_raw;
  logic [OUT_FBITS-1:0]      frac_trunc;
  logic [OUT_FBITS-1:0]      res_frac;
  logic signed [SC_W-1:0]    res_scale;

  posit_quire_align #(
    .SC_W (SC_W),
    .M_W  (M_W),
    .Q_W  (Q_W),
    .BIAS (2 * MAX_SC)
  ) u_align (
    .sgn   (in_sgn),
    .scale (in_scale),
    .frac  (in_frac),
    .term  (term)
  );

`ifdef POSIT_DOT_ACCUM_RNE_EN
  logic                      guard_bit, sticky_bit, round_up, carry;
  logic [OUT_FBITS-1:0]      frac_rnd;

  always_comb begin
    scale_raw           = (Q_W - 1) - int'(sh_q) - PT;
    frac_trunc          = quire_q[Q_W-2 -: OUT_FBITS];
    guard_bit           = quire_q[Q_W-2-OUT_FBITS];
    sticky_bit          = |quire_q[Q_W-3-OUT_FBITS:0];
    round_up            = guard_bit & (sticky_bit | frac_trunc[0]);
    // On mantissa overflow frac_rnd wraps to zero, which is exactly the renormalised fraction.
    {carry, frac_rnd}   = {1'b0, frac_trunc} + (OUT_FBITS+1)'(round_up);
    res_frac            = frac_rnd;
    res_scale           = SC_W'(clamp_scale(scale_raw + int'(carry), MAX_SC));
  end
`else
  always_comb begin
    scale_raw  = (Q_W - 1) - int'(sh_q) - PT;
    frac_trunc = quire_q[Q_W-2 -: OUT_FBITS];
    res_frac   = frac_trunc;
    res_scale  = SC_W'(clamp_scale(scale_raw, MAX_SC));
  end
`endif

  always_comb begin
    state_d     = state_q;
    quire_d     = quire_q;
    nar_d       = nar_q;
    sgn_d       = sgn_q;
    sh_d        = sh_q;
    out_sgn_d   = out_sgn_q;
    out_scale_d = out_scale_q;
    out_frac_d  = out_frac_q;
    out_inf_d   = out_inf_q;
    out_zero_d  = out_zero_q;

    unique case (state_q)
      ST_ACC: begin
        if (in_valid) begin
          if (!in_zero && !in_inf) quire_d = quire_q + term;
          if (in_inf) nar_d = 1'b1;
          if (in_last) state_d = ST_ABS;
        end
      end
      ST_ABS: begin
        sgn_d   = quire_q[Q_W-1];
        quire_d = quire_q[Q_W-1] ? -quire_q : quire_q;
        sh_d    = '0;
        if (nar_q || (quire_q == '0)) begin
          out_sgn_d   = 1'b0;
          out_scale_d = '0;
          out_frac_d  = '0;
          out_inf_d   = nar_q;
          out_zero_d  = !nar_q;
          state_d     = ST_OUT;
        end else begin
          state_d = ST_NORM;
        end
      end
      ST_NORM: begin
        // Coarse steps skip long runs of leading zeros; single-bit steps finish the job.
        if (quire_q[Q_W-1 -: CHUNK] == '0) begin
          quire_d = quire_q << CHUNK;
          sh_d    = sh_q + SHW'(CHUNK);
        end else if (!quire_q[Q_W-1]) begin
          quire_d = quire_q << 1;
          sh_d    = sh_q + SHW'(1);
        end else begin
`ifdef POSIT_DOT_ACCUM_RNE_EN
          state_d = ST_ROUND;
`else
          out_sgn_d   = sgn_q;
          out_scale_d = res_scale;
          out_frac_d  = res_frac;
          out_inf_d   = 1'b0;
          out_zero_d  = 1'b0;
          state_d     = ST_OUT;
`endif
        end
      end
`ifdef POSIT_DOT_ACCUM_RNE_EN
      ST_ROUND: begin
        out_sgn_d   = sgn_q;
        out_scale_d = res_scale;
        out_frac_d  = res_frac;
        out_inf_d   = 1'b0;
        out_zero_d  = 1'b0;
        state_d     = ST_OUT;
      end
`endif
      ST_OUT: begin
        if (out_ready) begin
          state_d = ST_ACC;
          quire_d = '0;
          nar_d   = 1'b0;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_ACC;
      quire_q     <= '0;
      nar_q       <= 1'b0;
      sgn_q       <= 1'b0;
      sh_q        <= '0;
      out_sgn_q   <= 1'b0;
      out_scale_q <= '0;
      out_frac_q  <= '0;
      out_inf_q   <= 1'b0;
      out_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      quire_q     <= quire_d;
      nar_q       <= nar_d;
      sgn_q       <= sgn_d;
      sh_q        <= sh_d;
      out_sgn_q   <= out_sgn_d;
      out_scale_q <= out_scale_d;
      out_frac_q  <= out_frac_d;
      out_inf_q   <= out_inf_d;
      out_zero_q  <= out_zero_d;
    end
  end

  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = (state_q == ST_OUT);
  assign out_sgn   = out_sgn_q;
  assign out_scale = out_scale_q;
  assign out_frac  = out_frac_q;
  assign out_inf   = out_inf_q;
  assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_posit_dot_accum.sv
// Bench for posit_dot_accum (32/2): directed scenarios plus random sums against an exact big-integer model.
// Build with POSIT_DOT_ACCUM_RNE_EN defined to check the rounding variant.
module tb_posit_dot_accum;
  import posit_defines::*;

  localparam int FW = DEF_OUT_FBITS;
  localparam int MW = MBITS;
  localparam int PT = 2 * MAXS + MBITS - 2;
  localparam logic [MW-1:0] ONE = 56'h40_0000_0000_0000;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid, in_ready, in_last, in_sgn, in_inf, in_zero;
  logic signed [SW-1:0] in_scale;
  logic [MW-1:0]        in_frac;
  logic                 out_valid, out_ready, out_sgn, out_inf, out_zero;
  logic signed [SW-1:0] out_scale;
  logic [FW-1:0]        out_frac;

  int n_cmp = 0;
  int n_bad = 0;

  logic signed [1023:0] model_acc;
  bit                   model_nar;

  always #5 clk = ~clk;

  posit_dot_accum dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .in_sgn    (in_sgn),
    .in_scale  (in_scale),
    .in_frac   (in_frac),
    .in_inf    (in_inf),
    .in_zero   (in_zero),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sgn   (out_sgn),
    .out_scale (out_scale),
    .out_frac  (out_frac),
    .out_inf   (out_inf),
    .out_zero  (out_zero)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic value_quire_out mk(input bit s, input int sc, input logic [FW-1:0] f,
                                        input bit inf, input bit zero);
    value_quire_out r;
    r.sgn = s; r.scale = SW'(sc); r.fraction = f; r.inf = inf; r.zero = zero;
    return r;
  endfunction

  task automatic model_clear();
    model_acc = '0;
    model_nar = 1'b0;
  endtask

  // Exact value of the sum in units of 2^-PT.
  task automatic model_add(input bit s, input int sc, input logic [MW-1:0] f, input bit inf, input bit zero);
    logic signed [1023:0] mag;
    if (inf) model_nar = 1'b1;
    if (!inf && !zero) begin
      mag = '0;
      mag[MW-1:0] = f;
      mag = mag << (sc + 2 * MAXS);
      model_acc = s ? model_acc - mag : model_acc + mag;
    end
  endtask

  function automatic value_quire_out model_result();
    value_quire_out r;
    logic [1023:0] a, nrm;
    logic [FW:0]   fr;
    int            p, sc;
    r = '0;
    if (model_nar) begin r.inf = 1'b1; return r; end
    if (model_acc == 0) begin r.zero = 1'b1; return r; end
    r.sgn = model_acc[1023];
    a = model_acc[1023] ? -model_acc : model_acc;
    p = 0;
    for (int i = 1023; i >= 0; i--) if (a[i]) begin p = i; break; end
    nrm = a << (1023 - p);
    sc  = p - PT;
    fr  = {1'b0, nrm[1022 -: FW]};
`ifdef POSIT_DOT_ACCUM_RNE_EN
    if (nrm[1022-FW] && ((|nrm[1021-FW:0]) || fr[0])) fr = fr + 1'b1;
    if (fr[FW]) sc = sc + 1;
`endif
    r.scale    = SW'(clamp_scale(sc, MAXS));
    r.fraction = fr[FW-1:0];
    return r;
  endfunction

  task automatic send_term(input bit s, input int sc, input logic [MW-1:0] f,
                           input bit inf, input bit zero, input bit last);
    int waited = 0;
    in_sgn = s; in_scale = SW'(sc); in_frac = f; in_inf = inf; in_zero = zero; in_last = last;
    in_valid = 1'b1;
    while (!in_ready && waited < 200) begin @(posedge clk); #1; waited++; end
    check_val("ready_wait", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    model_add(s, sc, f, inf, zero);
  endtask

  task automatic get_result(input string tag, input value_quire_out exp);
    value_quire_out got;
    int w = 0;
    while (!out_valid && w < 1000) begin @(posedge clk); #1; w++; end
    check_val({tag, "_valid"}, 64'(out_valid), 64'd1);
    got = {out_sgn, out_scale, out_frac, out_inf, out_zero};
    check_val(tag, 64'(got), 64'(exp));
    if (exp.inf || exp.zero) check_val({tag, "_lat"}, 64'(w + 1), 64'd2);
    $display("sum %s: sgn=%0d scale=%0d frac=%h inf=%0d zero=%0d latency=%0d",
             tag, out_sgn, out_scale, out_frac, out_inf, out_zero, w + 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    value_quire_out exp5;
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_sgn = 1'b0; in_scale = '0;
    in_frac = '0; in_inf = 1'b0; in_zero = 1'b0; out_ready = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_in_ready", 64'(in_ready), 64'd1);
    check_val("rst_fields", 64'({out_sgn, out_scale, out_frac, out_inf, out_zero}), 64'd0);

    // 1) 1+1+1 = 3
    model_clear();
    send_term(0, 0, ONE, 0, 0, 0);
    send_term(0, 0, ONE, 0, 0, 0);
    send_term(0, 0, ONE, 0, 0, 1);
    get_result("three_ones", mk(0, 1, 27'h400_0000, 0, 0));

    // 2) exact cancellation
    model_clear();
    send_term(0, 0, ONE, 0, 0, 0);
    send_term(1, 0, ONE, 0, 0, 1);
    get_result("cancel", mk(0, 0, 0, 0, 1));

    // 3) NaR is sticky within a sum, cleared after it
    model_clear();
    send_term(0, 0, ONE, 0, 0, 0);
    send_term(0, 0, '0, 1, 0, 0);
    send_term(0, 0, ONE, 0, 0, 1);
    get_result("nar", mk(0, 0, 0, 1, 0));
    model_clear();
    send_term(0, 0, ONE, 0, 0, 1);
    get_result("after_nar", mk(0, 0, 0, 0, 0));

    // 4) saturation at both ends
    model_clear();
    send_term(0, 240, ONE, 0, 0, 0);
    send_term(0, 240, ONE, 0, 0, 1);
    get_result("clamp_hi", mk(0, 120, 0, 0, 0));
    model_clear();
    send_term(0, -240, ONE, 0, 0, 0);
    send_term(0, -240, ONE, 0, 0, 1);
    get_result("clamp_lo", mk(0, -120, 0, 0, 0));

    // 5) backpressure: result held, new terms refused
    model_clear();
    send_term(0, 0, 56'h60_0000_0000_0000, 0, 0, 1);
    exp5 = mk(0, 0, 27'h400_0000, 0, 0);
    for (int w = 0; w < 1000 && !out_valid; w++) begin @(posedge clk); #1; end
    in_sgn = 1'b1; in_scale = SW'(5); in_frac = ONE; in_last = 1'b1; in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      check_val("hold_valid", 64'(out_valid), 64'd1);
      check_val("hold_ready", 64'(in_ready), 64'd0);
      check_val("hold_fields", 64'({out_sgn, out_scale, out_frac, out_inf, out_zero}), 64'(exp5));
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0; in_sgn = 1'b0;
    get_result("hold_release", exp5);
    model_clear();
    send_term(0, 0, ONE, 0, 0, 1);
    get_result("after_hold", mk(0, 0, 0, 0, 0));

    // 6) reset in the middle of normalisation
    model_clear();
    send_term(0, -240, 56'h1, 0, 0, 1);
    @(posedge clk); #1;
    check_val("norm_busy", 64'(out_valid), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_val("mid_rst_valid", 64'(out_valid), 64'd0);
    check_val("mid_rst_ready", 64'(in_ready), 64'd1);
    model_clear();
    send_term(0, 0, ONE, 0, 0, 1);
    get_result("after_rst", mk(0, 0, 0, 0, 0));

    // random sums against the exact model
    for (int n = 0; n < 40; n++) begin
      int nt;
      bit narrow;
      model_clear();
      nt = $urandom_range(1, 6);
      narrow = ($urandom_range(0, 1) == 1);
      for (int t = 0; t < nt; t++) begin
        logic [MW-1:0] f;
        int sc;
        bit z, nr;
        f = MW'({$urandom, $urandom});
        if (f[MW-1:MW-2] == 2'b00) f[MW-2] = 1'b1;
        sc = narrow ? $urandom_range(0, 16) - 8 : $urandom_range(0, 480) - 240;
        z  = ($urandom_range(0, 9) == 0);
        nr = ($urandom_range(0, 29) == 0);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        send_term($urandom_range(0, 1) == 1, sc, f, nr, z, t == nt - 1);
      end
      get_result($sformatf("rand%0d", n), model_result());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
